data_matrix_mem_access: RTL and testbench

//  LC-3 memory-access datapath: MAR/MDR pair plus request/acknowledge engine toward
//  the memory port. Peer of the PC load path: that path sources addresses onto the

---
 rtl/data_matrix_mem_access_if.sv | 21 ++
 rtl/data_matrix_mem_access.sv | 131 +++++++++++++
 tb/tb_data_matrix_mem_access.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_matrix_mem_access_if.sv
// Memory-port bundle between the LC-3 MAR/MDR access engine and the memory.
interface data_matrix_mem_access_if #(
  parameter int unsigned DW = 16
) ();
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/data_matrix_mem_access.sv
// LC-3 memory-access datapath: MAR/MDR registers and a request/acknowledge
// engine with timeout toward the memory port.
module data_matrix_mem_access #(
  parameter int unsigned   DW       = 16,
  parameter int unsigned   TIMEOUT  = 255,
  parameter logic [DW-1:0] TMO_DATA = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DW-1:0]                    i_bus,
  input  logic                             i_ld_mar,
  input  logic                             i_ld_mdr,
  input  logic                             i_mio_en,
  input  logic                             i_r_w,
  input  logic                             i_gate_mdr,
  output wire  [DW-1:0]                    o_mdr_bus,
  output logic [DW-1:0]                    o_mar,
  output logic                             o_r,
  output logic                             o_err,
  data_matrix_mem_access_if.master         mem_if
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic          r_armed;
  logic          r_we;
  logic          r_mem_req;
  logic          r_r;
  logic          r_err;
  logic [DW-1:0] r_mar;
  logic [DW-1:0] r_mdr;
  logic [DW-1:0] r_rdata_q;
  logic [CW-1:0] r_tmo_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_tmo_hit;
  logic          w_start;
  logic          w_ack;
  logic          w_tmo;

  assign w_cnt_inc = r_tmo_cnt + CW'(1);
  assign w_tmo_hit = (w_cnt_inc == CW'(TIMEOUT));

  // Next-state decode; an ack in the final timeout cycle takes priority.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ack       = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_mio_en && r_armed) begin
          w_start     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (mem_if.mem_ack) begin
          w_ack       = 1'b1;
          w_state_nxt = DONE;
        end else if (w_tmo_hit) begin
          w_tmo       = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Handshake outputs and access bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_req <= 1'b0;
      r_r       <= 1'b0;
      r_err     <= 1'b0;
      r_we      <= 1'b0;
      r_armed   <= 1'b1;
      r_tmo_cnt <= '0;
      r_rdata_q <= '0;
    end else begin
      r_mem_req <= (w_state_nxt == REQ);
      r_r       <= (w_state_nxt == DONE);
      if (w_start) begin
        r_we      <= i_r_w;
        r_armed   <= 1'b0;
        r_tmo_cnt <= '0;
      end else if (!i_mio_en && (r_state != REQ)) begin
        r_armed <= 1'b1;
      end
      if (r_state == REQ) r_tmo_cnt <= w_cnt_inc;
      if (w_ack && !r_we) r_rdata_q <= mem_if.mem_rdata;
      if (w_tmo) begin
        r_rdata_q <= TMO_DATA;
        r_err     <= 1'b1;
      end
    end
  end

  // MAR/MDR only accept new contents outside an access, except read-back in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mar <= '0;
      r_mdr <= '0;
    end else begin
      if (i_ld_mar && (r_state == IDLE)) r_mar <= i_bus;
      if (i_ld_mdr && !i_mio_en && (r_state == IDLE)) r_mdr <= i_bus;
      else if (i_ld_mdr && i_mio_en && (r_state == DONE) && !r_we) r_mdr <= r_rdata_q;
    end
  end

  assign o_mdr_bus        = i_gate_mdr ? r_mdr : {DW{1'bz}};
  assign o_mar            = r_mar;
  assign o_r              = r_r;
  assign o_err            = r_err;
  assign mem_if.mem_req   = r_mem_req;
  assign mem_if.mem_we    = r_we;
  assign mem_if.mem_addr  = r_mar;
  assign mem_if.mem_wdata = r_mdr;

endmodule

// File: tb/tb_data_matrix_mem_access.sv
// Bench for data_matrix_mem_access: directed LC-3 memory accesses checked every
// cycle against a transaction-level reference model, plus literal spot checks.
module tb_data_matrix_mem_access;
  localparam int unsigned DW  = 16;
  localparam int unsigned TMO = 4;
  localparam logic [DW-1:0] TMO_VAL = 16'h0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] bus = '0;
  logic          ld_mar = 1'b0, ld_mdr = 1'b0, mio_en = 1'b0, r_w = 1'b0, gate_mdr = 1'b1;
  logic [DW-1:0] rdata = '0;
  logic          ack = 1'b0;
  wire  [DW-1:0] mdr_bus;
  logic [DW-1:0] mar;
  logic          r_o, err_o;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  data_matrix_mem_access_if #(.DW(DW)) mem_if ();
  assign mem_if.mem_ack   = ack;
  assign mem_if.mem_rdata = rdata;

  data_matrix_mem_access #(.DW(DW), .TIMEOUT(TMO), .TMO_DATA(TMO_VAL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_bus      (bus),
    .i_ld_mar   (ld_mar),
    .i_ld_mdr   (ld_mdr),
    .i_mio_en   (mio_en),
    .i_r_w      (r_w),
    .i_gate_mdr (gate_mdr),
    .o_mdr_bus  (mdr_bus),
    .o_mar      (mar),
    .o_r        (r_o),
    .o_err      (err_o),
    .mem_if     (mem_if)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one access is a request phase of up to TMO cycles followed by
  // one ready cycle; registers change only at the points the access protocol allows.
  bit            m_busy, m_ready, m_armed, m_we, m_err;
  int            m_wait;
  logic [DW-1:0] m_mar, m_mdr, m_rd;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_ready = 0; m_armed = 1; m_we = 0; m_err = 0; m_wait = 0;
      m_mar = '0; m_mdr = '0; m_rd = '0;
    end else if (m_ready) begin
      if (ld_mdr && mio_en && !m_we) m_mdr = m_rd;
      if (!mio_en) m_armed = 1;
      m_ready = 0;
    end else if (m_busy) begin
      m_wait++;
      if (ack) begin
        if (!m_we) m_rd = rdata;
        m_busy = 0; m_ready = 1;
      end else if (m_wait == TMO) begin
        m_rd = TMO_VAL; m_err = 1;
        m_busy = 0; m_ready = 1;
      end
    end else begin
      if (ld_mar) m_mar = bus;
      if (ld_mdr && !mio_en) m_mdr = bus;
      if (mio_en && m_armed) begin
        m_busy = 1; m_wait = 0; m_we = r_w; m_armed = 0;
      end else if (!mio_en) begin
        m_armed = 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("mem_req", mem_if.mem_req, m_busy);
      chk("r", r_o, m_ready);
      chk("err", err_o, m_err);
      chk("mar", mar, m_mar);
      if (m_busy) begin
        chk("mem_addr", mem_if.mem_addr, m_mar);
        chk("mem_we", mem_if.mem_we, m_we);
        chk("mem_wdata", mem_if.mem_wdata, m_mdr);
      end
      if (gate_mdr) chk("mdr_bus", mdr_bus, m_mdr);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_r(input int maxc, output int cyc, output int reqc);
    cyc = 0; reqc = 0;
    while (!r_o && cyc < maxc) begin
      if (mem_if.mem_req) reqc++;
      tick();
      cyc++;
    end
    chk("r_seen", r_o, 1);
  endtask

  initial begin
    int cyc, reqc, cnt;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_mem_req", mem_if.mem_req, 0);
    chk("rst_r", r_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_mar", mar, 0);
    chk("rst_mdr", mdr_bus, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Write access, ack in the third request cycle
    bus = 16'h3000; ld_mar = 1; tick();
    ld_mar = 0; bus = 16'hBEEF; ld_mdr = 1; tick();
    ld_mdr = 0; mio_en = 1; r_w = 1; tick();
    chk("wr_addr", mem_if.mem_addr, 16'h3000);
    chk("wr_we", mem_if.mem_we, 1);
    chk("wr_wdata", mem_if.mem_wdata, 16'hBEEF);
    tick(); tick();
    chk("wr_req_held", mem_if.mem_req, 1);
    ack = 1; tick();
    ack = 0;
    chk("wr_r", r_o, 1);
    chk("wr_req_drop", mem_if.mem_req, 0);
    mio_en = 0; tick();
    chk("wr_r_pulse", r_o, 0);
    chk("wr_mdr_kept", mdr_bus, 16'hBEEF);

    // Zero-wait read with MDR load
    bus = 16'h0200; ld_mar = 1; tick();
    ld_mar = 0; mio_en = 1; r_w = 0; ld_mdr = 1; rdata = 16'h1234; ack = 1;
    wait_r(10, cyc, reqc);
    chk("rd_latency", cyc, 2);
    tick();
    ack = 0; ld_mdr = 0;
    chk("rd_mdr", mdr_bus, 16'h1234);

    // Held mio_en must not start another access
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_if.mem_req) cnt++;
    end
    chk("held_mio_bursts", cnt, 0);
    mio_en = 0; tick();
    mio_en = 1; tick();
    chk("rearm_req", mem_if.mem_req, 1);

    // MAR load ignored mid-access; ack outside REQ ignored
    bus = 16'hFFFF; ld_mar = 1; tick();
    ld_mar = 0;
    chk("req_mar_kept", mar, 16'h0200);
    chk("req_addr_kept", mem_if.mem_addr, 16'h0200);
    rdata = 16'h5555; ack = 1; tick();
    ack = 0;
    chk("second_r", r_o, 1);
    mio_en = 0; tick();
    ack = 1; cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (r_o) cnt++;
    end
    ack = 0;
    chk("idle_ack_r", cnt, 0);

    // Timeout read
    mio_en = 1; r_w = 0; ld_mdr = 1; rdata = 16'hABCD;
    wait_r(20, cyc, reqc);
    chk("tmo_req_cycles", reqc, TMO);
    chk("tmo_latency", cyc, TMO + 1);
    chk("tmo_err", err_o, 1);
    tick();
    chk("tmo_mdr", mdr_bus, 16'h0000);
    mio_en = 0; ld_mdr = 0;
    repeat (3) tick();
    chk("err_sticky", err_o, 1);

    // Asynchronous reset in the middle of a request
    mio_en = 1; r_w = 1; tick(); tick();
    chk("pre_rst_req", mem_if.mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req_drop", mem_if.mem_req, 0);
    chk("async_mar", mar, 0);
    chk("async_mdr", mdr_bus, 0);
    chk("async_err", err_o, 0);
    mio_en = 0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", mem_if.mem_req, 0);
    mio_en = 1; tick();
    chk("post_rst_start", mem_if.mem_req, 1);
    ack = 1; tick();
    ack = 0; mio_en = 0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, time %0t", $time);
    $fatal(1);
  end
endmodule
